// File: rtl/alu_mc_if.sv
// Operand/result bundle between the control FSM side and the multi-cycle ALU.
interface alu_mc_if #(
   parameter int unsigned WIDTH = 16
);
   logic             Start;
   logic [3:0]       ALU_Control;
   logic             Set_Flags;
   logic [WIDTH-1:0] Src_A;
   logic [WIDTH-1:0] Src_B;
   logic [WIDTH-1:0] ALU_Result;
   logic             N;
   logic             Z;
   logic             C;
   logic             V;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, ALU_Control, Set_Flags, Src_A, Src_B,
      input  ALU_Result, N, Z, C, V, Busy, Done
   );

   modport slave (
      input  Start, ALU_Control, Set_Flags, Src_A, Src_B,
      output ALU_Result, N, Z, C, V, Busy, Done
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier, with a registered NZCV flag register.
module alu_mc #(
   parameter int unsigned WIDTH = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_mc_if.slave  bus
);
   localparam int unsigned SH = $clog2(WIDTH);

   localparam logic [3:0] OpAdd = 4'b0000;
   localparam logic [3:0] OpSub = 4'b0001;
   localparam logic [3:0] OpAnd = 4'b0010;
   localparam logic [3:0] OpOr  = 4'b0011;
   localparam logic [3:0] OpXor = 4'b0100;
   localparam logic [3:0] OpClr = 4'b0101;
   localparam logic [3:0] OpAdc = 4'b0111;
   localparam logic [3:0] OpSbc = 4'b1000;
   localparam logic [3:0] OpLsl = 4'b1001;
   localparam logic [3:0] OpLsr = 4'b1010;
   localparam logic [3:0] OpAsr = 4'b1011;
   localparam logic [3:0] OpMul = 4'b1100;

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
   logic               done_q, done_d;
   logic               setf_q, setf_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SH-1:0]      cnt_q, cnt_d;

   logic [WIDTH-1:0]   a, b;
   logic [3:0]         op;
   logic [SH-1:0]      amt;
   logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, asr_w;
   logic               cin;
   logic [WIDTH-1:0]   alu_r;
   logic               alu_c, alu_v;
   logic [2*WIDTH-1:0] acc_sum;

   assign a   = bus.Src_A;
   assign b   = bus.Src_B;
   assign op  = bus.ALU_Control;
   assign amt = bus.Src_B[SH-1:0];

   // Single-cycle datapath: result and C/V for every non-MUL opcode
   always_comb begin
      cin   = ((op == OpAdc) || (op == OpSbc)) ? c_q : 1'b0;
      add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      // Bit WIDTH of the difference is the borrow (A < B + Cin)
      sub_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      shl_w = {1'b0, a} << amt;
      shr_w = {a, 1'b0} >> amt;
      asr_w = $unsigned($signed({a, 1'b0}) >>> amt);
      alu_r = b;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (op)
         OpAdd, OpAdc: begin
            alu_r = add_w[WIDTH-1:0];
            alu_c = add_w[WIDTH];
            alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub, OpSbc: begin
            alu_r = sub_w[WIDTH-1:0];
            alu_c = sub_w[WIDTH];
            alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
         end
         OpAnd: alu_r = a & b;
         OpOr:  alu_r = a | b;
         OpXor: alu_r = a ^ b;
         OpClr: alu_r = '0;
         OpLsl: begin
            alu_r = shl_w[WIDTH-1:0];
            alu_c = (amt == '0) ? c_q : shl_w[WIDTH];
         end
         OpLsr: begin
            alu_r = shr_w[WIDTH:1];
            alu_c = (amt == '0) ? c_q : shr_w[0];
         end
         OpAsr: begin
            alu_r = asr_w[WIDTH:1];
            alu_c = (amt == '0) ? c_q : asr_w[0];
         end
         default: alu_r = b;
      endcase
   end

   // Multiplier step: add the shifted multiplicand when the current bit is set
   always_comb begin
      acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Control FSM next-state, result/flag write-back and multiplier sequencing
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      n_d      = n_q;
      z_d      = z_q;
      c_d      = c_q;
      v_d      = v_q;
      done_d   = 1'b0;
      setf_d   = setf_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus.Start) begin
               if (op == OpMul) begin
                  state_d  = StMul;
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  setf_d   = bus.Set_Flags;
               end else begin
                  result_d = alu_r;
                  done_d   = 1'b1;
                  if (bus.Set_Flags) begin
                     n_d = alu_r[WIDTH-1];
                     z_d = (alu_r == '0);
                     c_d = alu_c;
                     v_d = alu_v;
                  end
               end
            end
         end
         StMul: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SH'(1);
            if (cnt_q == SH'(WIDTH - 1)) begin
               state_d  = StIdle;
               cnt_d    = '0;
               result_d = acc_sum[WIDTH-1:0];
               done_d   = 1'b1;
               if (setf_q) begin
                  n_d = acc_sum[WIDTH-1];
                  z_d = (acc_sum[WIDTH-1:0] == '0);
                  c_d = |acc_sum[2*WIDTH-1:WIDTH];
                  v_d = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset aborts any in-flight multiply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         result_q <= '0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         done_q   <= 1'b0;
         setf_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         n_q      <= n_d;
         z_q      <= z_d;
         c_q      <= c_d;
         v_q      <= v_d;
         done_q   <= done_d;
         setf_q   <= setf_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.ALU_Result = result_q;
   assign bus.N          = n_q;
   assign bus.Z          = z_q;
   assign bus.C          = c_q;
   assign bus.V          = v_q;
   assign bus.Busy       = (state_q == StMul);
   assign bus.Done       = done_q;
endmodule
